// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Definitions shared by the serial transmit and receive sides of the
// universal shift register link: the frame FSM state encoding, the
// shift-direction encoding and the start/stop line levels.
// No ports.
// ---------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // dir encoding: MSB first shifts left, LSB first shifts right
    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

    // Line levels: idle line is 0, a frame begins with a 1 and ends with a 0
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage : usr_pkg

// File: rtl/shift_in_reg.sv
// ---------------------------------------------------------------------------
// shift_in_reg
// WIDTH-bit serial-in shift register used to assemble a received word.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (register -> 0)
//   clr_sync  synchronous clear, has priority over shift_en
//   shift_en  shift one bit in this cycle
//   dir       DIR_MSB: shift left, new bit enters bit 0, first bit ends in MSB
//             DIR_LSB: shift right, new bit enters MSB, first bit ends in bit 0
//   sin       serial input bit
//   q         current register contents
// ---------------------------------------------------------------------------
module shift_in_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_sync,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr_sync) begin
            q <= '0;
        end else if (shift_en) begin
            if (dir == DIR_MSB) begin
                q <= {q[WIDTH-2:0], sin};
            end else begin
                q <= {sin, q[WIDTH-1:1]};
            end
        end
    end

endmodule : shift_in_reg

// File: rtl/serial_frame_deserializer.sv
// ---------------------------------------------------------------------------
// serial_frame_deserializer
// Receives framed serial data (start bit, WIDTH data bits, optional even
// parity bit, stop bit) and presents each good word on a registered parallel
// output with a valid/ready handshake. The output register is separate from
// the shift register, so a held word does not stall the next frame.
//
// Build option: define PARITY_EN to expect an even-parity bit after the data
// bits and enable par_err. Without it par_err is tied to 0.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   sin_valid  bit strobe qualifying sin
//   sin        serial data bit
//   dir        0 = MSB first, 1 = LSB first; latched with the start bit
//   out_ready  consumer accepts parout while out_valid = 1
//   parout     received word
//   out_valid  parout holds an unconsumed word
//   frm_err    one-cycle pulse: stop bit was 1, frame dropped
//   par_err    one-cycle pulse: parity mismatch, frame dropped
//   overrun    one-cycle pulse: good frame dropped, output still full
//   busy       receiver is inside a frame
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | line idle, waiting for a start bit
// ST_DATA | shifting in data bits, cnt counts bits already taken
// ST_PAR  | sampling the parity bit (PARITY_EN builds only)
// ST_STOP | sampling the stop bit and delivering / flagging the frame
// ---------------------------------------------------------------------------
module serial_frame_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             dir,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parout,
    output logic             out_valid,
    output logic             frm_err,
    output logic             par_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               dir_lat;
    logic [WIDTH-1:0]   shreg;

    logic               start_det;
    logic               data_shift;
    logic               stop_smp;
    logic               last_data;
    logic               stop_ok;
    logic               good;
    logic               load;
    logic               xfer;

`ifdef PARITY_EN
    logic               par_smp;
    logic               par_acc;
    logic               par_bad;
`endif

    assign last_data = (cnt == CNT_W'(WIDTH - 1));

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        start_det  = 1'b0;
        data_shift = 1'b0;
        stop_smp   = 1'b0;
`ifdef PARITY_EN
        par_smp    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (sin_valid && (sin == START_BIT)) begin
                    start_det = 1'b1;
                    state_nx  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sin_valid) begin
                    data_shift = 1'b1;
                    if (last_data) begin
`ifdef PARITY_EN
                        state_nx = ST_PAR;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end
            end
            ST_PAR: begin
`ifdef PARITY_EN
                if (sin_valid) begin
                    par_smp  = 1'b1;
                    state_nx = ST_STOP;
                end
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (sin_valid) begin
                    stop_smp = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // -----------------------------------------------------------------------
    // Bit counter and direction latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt     <= '0;
            dir_lat <= DIR_MSB;
        end else if (start_det) begin
            cnt     <= '0;
            dir_lat <= dir;
        end else if (data_shift) begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

    shift_in_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (clr),
        .clr_sync (start_det),
        .shift_en (data_shift),
        .dir      (dir_lat),
        .sin      (sin),
        .q        (shreg)
    );

    // -----------------------------------------------------------------------
    // Parity accumulator: par_acc is the XOR of the data bits, which is the
    // parity bit value that makes the total number of ones even.
    // -----------------------------------------------------------------------
`ifdef PARITY_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else if (start_det) begin
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else if (data_shift) begin
            par_acc <= par_acc ^ sin;
        end else if (par_smp) begin
            par_bad <= par_acc ^ sin;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Delivery at the stop-bit sample. Framing error beats parity error,
    // which beats overrun. A word leaving in the same cycle frees the slot.
    // -----------------------------------------------------------------------
    assign stop_ok = stop_smp && (sin == STOP_BIT);
`ifdef PARITY_EN
    assign good    = stop_ok && !par_bad;
`else
    assign good    = stop_ok;
`endif
    assign xfer    = out_valid && out_ready;
    assign load    = good && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            parout    <= '0;
            out_valid <= 1'b0;
            frm_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frm_err <= stop_smp && (sin != STOP_BIT);
            overrun <= good && out_valid && !out_ready;
            if (load) begin
                parout    <= shreg;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_err <= 1'b0;
        end else begin
            par_err <= stop_ok && par_bad;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule : serial_frame_deserializer

// File: tb/tb_serial_frame_deserializer.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_deserializer
// Directed frames with hand-computed expected words. Stimulus pushes the
// expected outcome of each frame into a queue; a monitor on the falling edge
// pops and compares whenever the DUT presents a new word or an error pulse.
// ---------------------------------------------------------------------------
module tb_serial_frame_deserializer;

    localparam int WIDTH = 4;

    localparam logic [1:0] EV_WORD = 2'd0;
    localparam logic [1:0] EV_FRM  = 2'd1;
    localparam logic [1:0] EV_PAR  = 2'd2;
    localparam logic [1:0] EV_OVR  = 2'd3;

    typedef struct {
        logic [1:0]       kind;
        logic [WIDTH-1:0] data;
    } ev_t;

    logic             clk;
    logic             clr;
    logic             sin_valid;
    logic             sin;
    logic             dir;
    logic             out_ready;
    logic [WIDTH-1:0] parout;
    logic             out_valid;
    logic             frm_err;
    logic             par_err;
    logic             overrun;
    logic             busy;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    serial_frame_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .sin_valid (sin_valid),
        .sin       (sin),
        .dir       (dir),
        .out_ready (out_ready),
        .parout    (parout),
        .out_valid (out_valid),
        .frm_err   (frm_err),
        .par_err   (par_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (time %0t)", name, act, req, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (time %0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    task automatic sb_pop(input logic [1:0] kind);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d parout %b, expected none (time %0t)",
                     kind, parout, $time);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind !== kind) begin
            n_fail++;
            $display("FAIL event_kind: got kind %0d, expected kind %0d (time %0t)",
                     kind, e.kind, $time);
        end else if ((kind == EV_WORD || kind == EV_OVR) && parout !== e.data) begin
            n_fail++;
            $display("FAIL event_parout: kind %0d got %b, expected %b (time %0t)",
                     kind, parout, e.data, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clr) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (out_valid && (!prev_valid || prev_ready)) sb_pop(EV_WORD);
            if (frm_err) sb_pop(EV_FRM);
            if (par_err) sb_pop(EV_PAR);
            if (overrun) sb_pop(EV_OVR);
            prev_valid = out_valid;
            prev_ready = out_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [1:0] kind, input logic [WIDTH-1:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called and returns at posedge+1.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            sin_valid = 1'b0;
            sin       = ~b;
            @(posedge clk); #1;
        end
        sin_valid = 1'b1;
        sin       = b;
        @(posedge clk); #1;
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    // dir is toggled right after the start bit; the DUT must ignore that.
    task automatic send_frame(input logic d, input logic [WIDTH-1:0] data,
                              input logic stopb, input logic parb,
                              input int gap, input logic rdy_stop);
        dir = d;
        send_bit(1'b1, gap);
        dir = ~d;
        for (int i = 0; i < WIDTH; i++) begin
            send_bit((d == 1'b0) ? data[WIDTH-1-i] : data[i], gap);
        end
`ifdef PARITY_EN
        send_bit(parb, gap);
`endif
        if (rdy_stop) out_ready = 1'b1;
        send_bit(stopb, gap);
        out_ready = 1'b0;
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_bit(name, out_valid, 1'b0);
    endtask

    initial begin
        clr       = 1'b1;
        sin_valid = 1'b0;
        sin       = 1'b0;
        dir       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk); #1;
        check_bit ("rst_out_valid", out_valid, 1'b0);
        check_word("rst_parout",    parout,    4'b0000);
        check_bit ("rst_busy",      busy,      1'b0);
        check_bit ("rst_frm_err",   frm_err,   1'b0);
        check_bit ("rst_overrun",   overrun,   1'b0);

        // MSB first 1011, then one cycle of ready
        push(EV_WORD, 4'b1011);
        send_frame(1'b0, 4'b1011, 1'b0, 1'b1, 0, 1'b0);
        check_bit("msb_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        consume("msb_consumed");

        // LSB first: data bits 1,1,0,1 in time order -> 1011
        push(EV_WORD, 4'b1011);
        send_frame(1'b1, 4'b1011, 1'b0, 1'b1, 0, 1'b0);
        consume("lsb_consumed");

        // Same, sin_valid every third cycle
        push(EV_WORD, 4'b1011);
        send_frame(1'b1, 4'b1011, 1'b0, 1'b1, 2, 1'b0);
        consume("gap_consumed");

        // Overrun: output full, second frame dropped, 0011 held
        push(EV_WORD, 4'b0011);
        push(EV_OVR,  4'b0011);
        send_frame(1'b0, 4'b0011, 1'b0, 1'b0, 0, 1'b0);
        send_frame(1'b0, 4'b1100, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        check_word("ovr_held", parout, 4'b0011);
        consume("ovr_consumed");

        // Ready on the second stop cycle: transfer and load together
        push(EV_WORD, 4'b0011);
        push(EV_WORD, 4'b1100);
        send_frame(1'b0, 4'b0011, 1'b0, 1'b0, 0, 1'b0);
        send_frame(1'b0, 4'b1100, 1'b0, 1'b0, 0, 1'b1);
        check_bit ("swap_valid",  out_valid, 1'b1);
        check_word("swap_parout", parout,    4'b1100);
        consume("swap_consumed");

        // Bad stop bit, then a good frame
        push(EV_FRM, 4'b0000);
        send_frame(1'b0, 4'b1110, 1'b1, 1'b1, 0, 1'b0);
        @(posedge clk); #1;
        check_bit("frm_no_valid", out_valid, 1'b0);
        push(EV_WORD, 4'b0101);
        send_frame(1'b0, 4'b0101, 1'b0, 1'b0, 0, 1'b0);
        consume("frm_next_consumed");

`ifdef PARITY_EN
        push(EV_WORD, 4'b1011);
        send_frame(1'b0, 4'b1011, 1'b0, 1'b1, 0, 1'b0);
        consume("par_ok_consumed");
        push(EV_PAR, 4'b0000);
        send_frame(1'b0, 4'b1011, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        check_bit("par_bad_no_valid", out_valid, 1'b0);
`endif

        // Reset mid-frame with a word still held
        push(EV_WORD, 4'b1001);
        send_frame(1'b0, 4'b1001, 1'b0, 1'b0, 0, 1'b0);
        dir = 1'b0;
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        check_bit("mid_busy", busy, 1'b1);
        clr = 1'b1;
        #1;
        check_bit ("clr_out_valid", out_valid, 1'b0);
        check_word("clr_parout",    parout,    4'b0000);
        check_bit ("clr_busy",      busy,      1'b0);
        check_bit ("clr_frm_err",   frm_err,   1'b0);
        check_bit ("clr_par_err",   par_err,   1'b0);
        check_bit ("clr_overrun",   overrun,   1'b0);
        @(posedge clk); #1;
        clr = 1'b0;
        push(EV_WORD, 4'b0110);
        send_frame(1'b0, 4'b0110, 1'b0, 1'b0, 0, 1'b0);
        consume("post_clr_consumed");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_frame_deserializer

// File: doc/serial_frame_deserializer.md
# serial_frame_deserializer

Receive-side counterpart of the universal shift register's serial output. Captures a framed serial bit stream (start bit, WIDTH data bits, optional parity bit, stop bit) into an internal shift register. Presents each completed word on a registered parallel output with a valid/ready handshake. Sits between the serial link and the parallel consumer, so a word held at the output does not stall reception of the next frame.

## Interface
- WIDTH, 4: data bits per frame (≥2)
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- sin_valid  in  1  qualifies sin this cycle (bit strobe)
- sin  in  1  serial data bit
- dir  in  1  0 = MSB first (shift left), 1 = LSB first (shift right); sampled with the start bit
- out_ready  in  1  consumer accepts parout when out_valid=1
- parout  out  WIDTH  received word
- out_valid  out  1  parout holds an unconsumed word
- frm_err  out  1  one-cycle pulse: bad stop bit, frame dropped
- par_err  out  1  one-cycle pulse: parity mismatch, frame dropped (constant 0 without PARITY_EN)
- overrun  out  1  one-cycle pulse: good frame dropped because output still full
- busy  out  1  state ≠ IDLE

## Operation
- One clock; clr is asynchronous and active-high. Ports are named clk and clr.
- States and transitions (advance only on cycles with sin_valid=1; sin ignored otherwise):
  - IDLE → DATA on sin=1 (start bit). Clear bit counter and latch dir. sin=0 in IDLE is idle line.
  - DATA: shift sin in per dir. When counter reaches WIDTH-1, go to PAR (PARITY_EN) or STOP.
  - PAR: compare sin against even parity of the captured bits, record the result, go to STOP.
  - STOP: stop bit must be 0; always return to IDLE.
- Delivery at the STOP sample, with this priority:
  1. stop bit = 1 → frm_err.
  2. Otherwise parity mismatch → par_err.
  3. Otherwise, if out_valid=0 or (out_valid & out_ready) this cycle → load parout and set out_valid.
  4. Otherwise → overrun; parout and out_valid are unchanged.
- Handshake: transfer occurs when out_valid & out_ready. A transfer with no new load clears out_valid. A transfer with a simultaneous load keeps out_valid=1 with the new word.
- Bit order: with dir=0 the first data bit lands in parout[WIDTH-1]; with dir=1 it lands in parout[0].
- Changing dir mid-frame has no effect until the next start bit.

## Timing
- Reset (clr=1, at any time including mid-frame): state IDLE, counter 0, shift register 0, parout 0, out_valid 0, frm_err/par_err/overrun/busy 0. Any partial frame is discarded.
- Latency: out_valid rises on the clock edge that samples the stop bit. parout is valid the same cycle out_valid is seen high.
- Error pulses are asserted for exactly the one cycle following the stop-bit sample edge.
- Back-to-back frames: a start bit may be presented on the next sin_valid after the stop bit, with no gap cycles required.
- sin_valid may be held high continuously (one bit per clock) or gapped arbitrarily; gaps do not time out.

## Configuration
- PARITY_EN defined: each frame carries one even-parity bit between the data bits and the stop bit. Frame length is WIDTH+3 bits, and par_err is active.
- Not defined: no parity bit, frame length WIDTH+2 bits, PAR state absent, par_err tied 0.

## Structure
- Shared package usr_pkg holds:
  - state enum (ST_IDLE, ST_DATA, ST_PAR, ST_STOP)
  - DIR_MSB/DIR_LSB constants
  - the start/stop bit level constants
- Serial transmit side and receive side import the same package.
- Sub-module shift_in_reg: WIDTH-bit shift register with shift-enable, direction and synchronous clear. The FSM, counter, parity accumulator and output register stay in the top.

## Test plan
- Reset, then with dir=0 stream 1,1,0,1,1,0 (start, 1011, stop), no parity → parout=4'b1011 and out_valid=1 after the stop edge. Raising out_ready for one cycle → out_valid=0.
- dir=1 with data bits 1,1,0,1 → parout=4'b1011. Same stream with gapped sin_valid (every third cycle) → identical result.
- Hold out_ready=0 and send two good frames 4'b0011 then 4'b1100 → overrun pulses once and parout stays 4'b0011. Repeat with out_ready=1 on the second stop cycle → no overrun, parout=4'b1100.
- Stop bit sent as 1 → frm_err one-cycle pulse, out_valid stays 0, and the next good frame is received normally.
- PARITY_EN: data 4'b1011 with parity bit 1 → delivered. With parity bit 0 → par_err pulse, no delivery.
- Assert clr after the second data bit → all outputs 0 immediately. A fresh frame 4'b0110 after release is received correctly.
